// File: rtl/blk_1279bc_pkg.sv
// Shared constants, FSM encoding and width helper for the m_axi burst writer.
package blk_1279bc_pkg;

  localparam int unsigned RESP_OKAY   = 0;
  localparam int unsigned BOUNDARY_4K = 4096;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_AW     = 3'd1,
    ST_W      = 3'd2,
    ST_WAIT_B = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/blk_1279bc_burst_calc.sv
// Burst sizing: beats = min(remaining, MAX_BURST, beats left before the next 4 KB page),
// plus the address that follows the burst.
module blk_1279bc_burst_calc
  import blk_1279bc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 32,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned BEAT_W     = 5
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LEN_WIDTH-1:0]  remaining,
  output logic [BEAT_W-1:0]     beats,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  localparam int unsigned BPB_SHIFT = $clog2(DATA_WIDTH / 8);

  logic [12:0]          to_4k;
  logic [LEN_WIDTH-1:0] lim;

  always_comb begin
    to_4k = (13'(BOUNDARY_4K) - {1'b0, addr[11:0]}) >> BPB_SHIFT;
    lim   = remaining;
    if (lim > LEN_WIDTH'(MAX_BURST)) lim = LEN_WIDTH'(MAX_BURST);
    if (lim > LEN_WIDTH'(to_4k))     lim = LEN_WIDTH'(to_4k);
    beats     = BEAT_W'(lim);
    next_addr = addr + (ADDR_WIDTH'(beats) << BPB_SHIFT);
  end

endmodule

// File: rtl/blk_1279bc.sv
// AXI4 write master for the output drainer fp32 mmap port: splits one request into
// bounded AW/W bursts and reports completion once every B response has returned.
module blk_1279bc
  import blk_1279bc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned LEN_WIDTH       = 32,
  parameter int unsigned MAX_BURST       = 16,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [LEN_WIDTH-1:0]    req_len,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned BEAT_W = cnt_width(MAX_BURST);
  localparam int unsigned OUT_W  = cnt_width(MAX_OUTSTANDING);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, awaddr_q, calc_addr, calc_next;
  logic [LEN_WIDTH-1:0]  rem_q, calc_rem;
  logic [BEAT_W-1:0]     beat_cnt_q, calc_beats;
  logic [OUT_W-1:0]      out_q, out_d;
  logic [7:0]            awlen_q;
  logic                  awvalid_q, awvalid_d, done_q, done_d;
  logic                  err_q, req_ready_q, bready_q;
  logic                  accept, aw_hs, w_hs, b_hs, last_beat;

  assign accept    = (state_q == ST_IDLE) && req_ready_q && req_valid;
  assign aw_hs     = (state_q == ST_AW) && awvalid_q && m_axi_awready;
  assign w_hs      = (state_q == ST_W) && s_valid && m_axi_wready;
  assign b_hs      = bready_q && m_axi_bvalid;
  assign last_beat = (beat_cnt_q == BEAT_W'(1));

  // In IDLE size the first burst straight from the request so AW can follow acceptance.
  assign calc_addr = (state_q == ST_IDLE) ? req_addr : addr_q;
  assign calc_rem  = (state_q == ST_IDLE) ? req_len  : rem_q;

  blk_1279bc_burst_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .MAX_BURST  (MAX_BURST),
    .BEAT_W     (BEAT_W)
  ) u_calc (
    .addr      (calc_addr),
    .remaining (calc_rem),
    .beats     (calc_beats),
    .next_addr (calc_next)
  );

  always_comb begin
    out_d = out_q;
    case ({aw_hs, b_hs})
      2'b10:   out_d = out_q + OUT_W'(1);
      2'b01:   if (out_q != '0) out_d = out_q - OUT_W'(1);
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = (req_len == '0) ? ST_DONE : ST_AW;
      ST_AW:     if (aw_hs) state_d = ST_W;
      ST_W:      if (w_hs && last_beat) state_d = (rem_q != '0) ? ST_AW : ST_WAIT_B;
      ST_WAIT_B: if (out_d == '0) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    awvalid_d = 1'b0;
    done_d    = 1'b0;
    if (state_d == ST_AW && out_d < OUT_W'(MAX_OUTSTANDING)) awvalid_d = 1'b1;
    if (state_d == ST_DONE) done_d = 1'b1;
  end

  // Registered outputs, address/length bookkeeping and the outstanding-B counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      rem_q       <= '0;
      beat_cnt_q  <= '0;
      out_q       <= '0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      awvalid_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
      bready_q    <= 1'b0;
    end else begin
      req_ready_q <= (state_d == ST_IDLE);
      bready_q    <= 1'b1;
      awvalid_q   <= awvalid_d;
      done_q      <= done_d;
      out_q       <= out_d;
      if (accept) begin
        addr_q <= req_addr;
        rem_q  <= req_len;
        err_q  <= 1'b0;
      end else if (aw_hs) begin
        addr_q <= calc_next;
        rem_q  <= rem_q - LEN_WIDTH'(calc_beats);
      end
      if (b_hs && m_axi_bresp != 2'(RESP_OKAY)) err_q <= 1'b1;
      if (aw_hs)     beat_cnt_q <= calc_beats;
      else if (w_hs) beat_cnt_q <= beat_cnt_q - BEAT_W'(1);
      if (state_d == ST_AW && state_q != ST_AW) begin
        awaddr_q <= calc_addr;
        awlen_q  <= 8'(calc_beats - BEAT_W'(1));
      end
    end
  end

  assign req_ready     = req_ready_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = s_data;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = (state_q == ST_W) && s_valid;
  assign m_axi_wlast   = (state_q == ST_W) && last_beat;
  assign s_ready       = (state_q == ST_W) && m_axi_wready;
  assign m_axi_bready  = bready_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_blk_1279bc.sv
// Scoreboard bench for blk_1279bc: requests are split by a reference model into expected
// AW/W/done items that monitors pop and compare as the DUT handshakes.
module tb_blk_1279bc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] req_addr;
  logic [31:0] req_len;
  logic        req_valid, req_ready;
  logic [31:0] s_data;
  logic        s_valid, s_ready;
  logic [63:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic        done, err;

  blk_1279bc dut (
    .clk(clk), .reset_n(reset_n),
    .req_addr(req_addr), .req_len(req_len), .req_valid(req_valid), .req_ready(req_ready),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .done(done), .err(err)
  );

  initial forever #5 clk = ~clk;

  int          checks = 0, errors = 0;
  int          aw_cnt = 0, done_cnt = 0, b_pend = 0;
  bit          all_ready = 1'b1, hold_b = 1'b0;
  logic [71:0] aw_q[$];
  logic [32:0] w_q[$];
  bit          done_q[$];
  logic [1:0]  bresp_q[$];
  logic [31:0] src_q[$];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_unexpected(input string name, input logic [71:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected 0x%0h, required none", name, act);
  endtask

  // Monitor: pops expected items on every DUT handshake.
  always @(negedge clk) begin
    if (reset_n) begin
      if (m_axi_awvalid && m_axi_awready) begin
        aw_cnt++;
        if (aw_q.size() == 0) note_unexpected("aw", {m_axi_awaddr, m_axi_awlen});
        else chk("aw_addr_len", {m_axi_awaddr, m_axi_awlen}, aw_q.pop_front());
      end
      if (m_axi_wvalid && m_axi_wready) begin
        chk("wstrb", 72'(m_axi_wstrb), 72'hf);
        if (w_q.size() == 0) note_unexpected("w", 72'({m_axi_wdata, m_axi_wlast}));
        else chk("w_data_last", 72'({m_axi_wdata, m_axi_wlast}), 72'(w_q.pop_front()));
      end
      if (done) begin
        done_cnt++;
        if (done_q.size() == 0) note_unexpected("done", 72'(err));
        else chk("done_err", 72'(err), 72'(done_q.pop_front()));
      end
    end
  end

  // Beat source: presents queued data with random gaps.
  initial begin
    bit hs;
    s_valid = 1'b0;
    s_data  = '0;
    forever begin
      @(negedge clk);
      hs = s_valid && s_ready;
      @(posedge clk); #1;
      if (!reset_n) begin
        src_q.delete();
        s_valid = 1'b0;
      end else begin
        if (hs && src_q.size() > 0) void'(src_q.pop_front());
        if (src_q.size() > 0 && (all_ready || $urandom_range(3) != 0)) begin
          s_valid = 1'b1;
          s_data  = src_q[0];
        end else begin
          s_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_axi_awready = all_ready || ($urandom_range(2) != 0);
      m_axi_wready  = all_ready || ($urandom_range(3) != 0);
    end
  end

  // B responder: one response per accepted AW, in order, using the planned bresp.
  initial begin
    bit awh, bh;
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
    forever begin
      @(negedge clk);
      awh = m_axi_awvalid && m_axi_awready;
      bh  = m_axi_bvalid && m_axi_bready;
      @(posedge clk); #1;
      if (!reset_n) begin
        b_pend = 0;
        m_axi_bvalid = 1'b0;
      end else begin
        if (awh) b_pend++;
        if (bh) begin
          b_pend--;
          if (bresp_q.size() > 0) void'(bresp_q.pop_front());
        end
        if (b_pend > 0 && !hold_b &&
            ((m_axi_bvalid && !bh) || all_ready || $urandom_range(1) == 1)) begin
          m_axi_bvalid = 1'b1;
          m_axi_bresp  = (bresp_q.size() > 0) ? bresp_q[0] : 2'b00;
        end else begin
          m_axi_bvalid = 1'b0;
        end
      end
    end
  end

  // Reference model: page- and MAX_BURST-bounded split, then issue the request.
  task automatic do_req(input logic [63:0] a, input int unsigned len, input int bad_idx,
                        input bit rand_err);
    logic [63:0] ad;
    int unsigned rem;
    bit          e;
    int          bi, n;
    ad = a; rem = len; e = 1'b0; bi = 0; n = 0;
    while (rem > 0) begin
      int unsigned room, b;
      logic [1:0]  rsp;
      logic [31:0] d;
      room = (4096 - int'(ad[11:0])) / 4;
      b = rem;
      if (b > 16) b = 16;
      if (b > room) b = room;
      aw_q.push_back({ad, 8'(b - 1)});
      for (int k = 0; k < int'(b); k++) begin
        d = $urandom;
        src_q.push_back(d);
        w_q.push_back({d, k == int'(b) - 1});
      end
      rsp = (bi == bad_idx) ? 2'd2 : ((rand_err && $urandom_range(7) == 0) ? 2'd3 : 2'd0);
      bresp_q.push_back(rsp);
      e = e | (rsp != 2'd0);
      ad += 64'(b * 4);
      rem -= b;
      bi++;
    end
    done_q.push_back(e);
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) note_unexpected("req_ready_timeout", 72'(n));
    req_addr  = a;
    req_len   = len;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    if (len == 0) chk("done_latency", 72'(done), 72'(1));
    else          chk("aw_latency", 72'(m_axi_awvalid), 72'(1));
  endtask

  task automatic wait_done(input int base, input int budget);
    int n;
    n = 0;
    while (done_cnt == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == base) note_unexpected("done_timeout", 72'(n));
    repeat (3) @(negedge clk);
    chk("done_once", 72'(done_cnt - base), 72'(1));
    chk("aw_drained", 72'(aw_q.size()), 72'(0));
    chk("w_drained", 72'(w_q.size()), 72'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    logic [63:0] a;
    reset_n = 1'b0; req_addr = '0; req_len = '0; req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 72'(req_ready), 72'(0));
    chk("rst_awvalid", 72'(m_axi_awvalid), 72'(0));
    chk("rst_wvalid", 72'(m_axi_wvalid), 72'(0));
    chk("rst_wlast", 72'(m_axi_wlast), 72'(0));
    chk("rst_done_err", 72'({done, err}), 72'(0));
    chk("rst_bready", 72'(m_axi_bready), 72'(0));
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_req_ready", 72'(req_ready), 72'(1));
    chk("post_rst_bready", 72'(m_axi_bready), 72'(1));

    // Directed cases with everything ready.
    base = done_cnt; do_req(64'h1000, 4, -1, 0);  wait_done(base, 500);
    base = done_cnt; do_req(64'h0, 40, -1, 0);    wait_done(base, 500);
    base = done_cnt; do_req(64'hFF8, 4, -1, 0);   wait_done(base, 500);

    // Outstanding limit: B withheld, AW must stop after eight bursts.
    hold_b = 1'b1;
    base = done_cnt; n = aw_cnt;
    do_req(64'h0, 160, -1, 0);
    for (int i = 0; i < 1000 && aw_cnt - n < 8; i++) @(negedge clk);
    repeat (40) @(negedge clk);
    chk("stall_aw_count", 72'(aw_cnt - n), 72'(8));
    chk("stall_awvalid", 72'(m_axi_awvalid), 72'(0));
    hold_b = 1'b0;
    wait_done(base, 2000);
    chk("total_aw_after_stall", 72'(aw_cnt - n), 72'(10));

    // Error response on the middle burst, then a clean request.
    base = done_cnt; do_req(64'h0, 40, 1, 0);     wait_done(base, 500);
    base = done_cnt; do_req(64'h1000, 4, -1, 0);
    chk("err_cleared", 72'(err), 72'(0));
    wait_done(base, 500);

    base = done_cnt; do_req(64'h2000, 0, -1, 0);  wait_done(base, 50);

    // Randomized requests with random backpressure and errors.
    all_ready = 1'b0;
    for (int t = 0; t < 25; t++) begin
      a = {$urandom, $urandom};
      if ($urandom_range(1) == 1) a[11:0] = 12'(4096 - 4 * $urandom_range(1, 24));
      else                        a[11:0] = 12'(4 * $urandom_range(0, 1023));
      base = done_cnt;
      do_req(a, $urandom_range(0, 70), -1, 1);
      wait_done(base, 4000);
    end

    // Reset in the middle of a W burst abandons the transfer.
    all_ready = 1'b1;
    do_req(64'h0, 40, -1, 0);
    n = 0;
    while (!m_axi_wvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_reached_w", 72'(m_axi_wvalid), 72'(1));
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    chk("midrst_awvalid", 72'(m_axi_awvalid), 72'(0));
    chk("midrst_wvalid", 72'(m_axi_wvalid), 72'(0));
    chk("midrst_s_ready", 72'(s_ready), 72'(0));
    chk("midrst_done", 72'(done), 72'(0));
    aw_q.delete(); w_q.delete(); done_q.delete(); bresp_q.delete(); src_q.delete();
    base = done_cnt;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_req_ready", 72'(req_ready), 72'(1));
    repeat (20) @(negedge clk);
    chk("midrst_no_done", 72'(done_cnt - base), 72'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blk_1279bc.md
Name: output_drainer_q_fp32_output_mmap_m_axi_burst_writer

Overview:
AXI4 write-channel master for the output drainer's fp32 mmap port. It accepts one write request (byte address plus beat count) and a data beat stream. It splits the transfer into AW/W bursts that never exceed MAX_BURST beats or cross a 4 KB boundary, and counts B responses before reporting completion. Its AW/W outputs feed the m_axi register slices; B comes back from them.

Parameters:
ADDR_WIDTH, 64, byte address width
DATA_WIDTH, 32, W beat width; bytes per beat = DATA_WIDTH/8 (power of 2)
LEN_WIDTH, 32, request beat-count width
MAX_BURST, 16, max beats per burst (1..256)
MAX_OUTSTANDING, 8, max AW issued without a matching B

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_addr  in  ADDR_WIDTH  start byte address, beat-aligned
req_len  in  LEN_WIDTH  number of beats
req_valid  in  1  request valid
req_ready  out  1  high only in IDLE
s_data  in  DATA_WIDTH  write beat stream
s_valid  in  1  beat valid
s_ready  out  1  beat accepted when s_valid & s_ready
m_axi_awaddr  out  ADDR_WIDTH  burst address
m_axi_awlen  out  8  beats-1
m_axi_awvalid  out  1  AW valid
m_axi_awready  in  1  AW ready
m_axi_wdata  out  DATA_WIDTH  equals s_data
m_axi_wstrb  out  DATA_WIDTH/8  all ones
m_axi_wlast  out  1  last beat of the current burst
m_axi_wvalid  out  1  W valid
m_axi_wready  in  1  W ready
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  B valid
m_axi_bready  out  1  constant 1 after reset
done  out  1  one-cycle pulse when the request completes
err  out  1  sticky for the request; valid while done=1

Behaviour:
- Reset (async assert, sync release): state IDLE; req_ready=0 during reset and 1 the cycle after release. awvalid=0, wvalid=0, wlast=0, done=0, err=0, bready=0. All counters cleared. Asserting reset mid-transfer abandons the transfer; there is no drain and no done pulse.
- States: IDLE, AW, W, WAIT_B, DONE.
- IDLE: on req_valid & req_ready, latch addr and remaining=req_len, clear err. If req_len==0, go to DONE; otherwise go to AW.
- AW burst length: beats = min(remaining, MAX_BURST, (4096 - addr[11:0]) / bytes_per_beat).
- AW: awvalid is registered and asserted only when outstanding < MAX_OUTSTANDING. awaddr/awlen stay stable while awvalid=1. On handshake: outstanding++, addr += beats*bytes_per_beat, remaining -= beats, beat_cnt=beats, go to W.
- W: wvalid = s_valid; s_ready = wready (pass-through, zero latency). wlast = (beat_cnt==1). On each W handshake beat_cnt--. After the last beat: go to AW if remaining>0, else to WAIT_B.
- WAIT_B: when outstanding==0, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- B channel: each bvalid & bready decrements outstanding. A B handshake in the same cycle as an AW handshake leaves outstanding unchanged. bresp != 0 sets err; err holds until the next request is accepted.
- Outside the W state, s_ready=0 and wvalid=0.
- Boundaries:
  - A 4 KB crossing always splits the burst.
  - A request longer than MAX_BURST produces ceil-style multiple bursts.
  - When outstanding hits MAX_OUTSTANDING, AW stalls with awvalid=0.
- Latency: first awvalid appears 1 cycle after request acceptance. done rises 1 cycle after the final B handshake, or 1 cycle after acceptance when req_len==0.

Decomposition:
- Shared package: AXI burst/resp constants (RESP_OKAY=0, BOUNDARY_4K=4096), FSM state encoding, beat-count width helper.
- One natural sub-module, output_drainer_q_fp32_output_mmap_m_axi_burst_calc: combinational beats = min(remaining, MAX_BURST, to-4K) and next-address computation, unit-testable alone.

Test Plan:
- addr=0x1000, len=4, all ready=1 -> one AW (addr 0x1000, awlen 3); wlast on beat 4; one B OKAY; done with err=0.
- addr=0x0, len=40, MAX_BURST=16 -> AWs at 0x0/len15, 0x40/len15, 0x80/len7; 40 W beats; 3 B; done once.
- addr=0xFF8, len=4 (4-byte beats) -> AW 0xFF8 awlen 1, then AW 0x1000 awlen 1; no burst crosses 4K.
- Hold bvalid=0 with len=16*10, MAX_OUTSTANDING=8 -> exactly 8 AWs, then awvalid stays 0; releasing one B enables the 9th AW.
- Return bresp=2 on the second of 3 bursts -> done with err=1; the next request starts with err=0.
- len=0 -> no AW/W; done pulse 1 cycle after accept. Separately, reset_n low mid-W-burst -> all valids 0 immediately, IDLE after release, no done.
